// File: rtl/tx_scheduler_if.sv
// Requester handshake and TX datapath bus of the TX scheduler.
// The master side is the requester / TX-datapath environment; the slave side is the scheduler.
interface tx_scheduler_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_active;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, tx_data, tx_valid, tx_active
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, tx_data, tx_valid, tx_active
  );
endinterface

// File: rtl/tx_scheduler.sv
// TX scheduler: sequences the link (OFF -> TRAIN -> IDLE/SEND) and shares the
// 32-bit TX word between two requesters with round-robin, burst-limited arbitration.
module tx_scheduler #(
  parameter int unsigned INIT_WORDS = 4,
  parameter logic [31:0] COM_WORD   = 32'hBCBCBCBC,
  parameter logic [31:0] IDLE_WORD  = 32'h7C7C7C7C,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic           clk_f,
  input  logic           reset,
  input  logic           enable,
  tx_scheduler_if.slave  bus,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_IDLE  = 2'd2,
    ST_SEND  = 2'd3
  } state_e;

  localparam int unsigned CW = $clog2(INIT_WORDS + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] TRAIN_LAST = CW'(INIT_WORDS - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

  state_e        state_q, state_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_active_q, tx_active_d;
  logic [CW-1:0] train_cnt_q, train_cnt_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;

  logic arb_on;
  logic own_valid;
  logic oth_valid;
  logic grant_any;
  logic grant_pick;

  // Arbitration: pick a requester from registered state and the valids only (never from ready).
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant_any  = 1'b0;
    grant_pick = owner_q;
    arb_on     = enable && (state_q == ST_IDLE || state_q == ST_SEND);
    own_valid  = owner_q ? bus.req1_valid : bus.req0_valid;
    oth_valid  = owner_q ? bus.req0_valid : bus.req1_valid;
    if (arb_on) begin
      if (state_q == ST_IDLE && bus.req0_valid && bus.req1_valid) begin
        // Fresh contention from idle: alternate away from the last winner.
        grant_any  = 1'b1;
        grant_pick = ~last_grant_q;
      end else if (own_valid && (burst_q < BURST_MAX || !oth_valid)) begin
        grant_any  = 1'b1;
        grant_pick = owner_q;
      end else if (oth_valid) begin
        grant_any  = 1'b1;
        grant_pick = ~owner_q;
      end
    end
  end

  assign bus.req0_ready = grant_any && !grant_pick;
  assign bus.req1_ready = grant_any &&  grant_pick;

  // State register plus datapath registers; reset is asynchronous and immediate.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OFF;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_active_q  <= 1'b0;
      train_cnt_q  <= '0;
      burst_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_active_q  <= tx_active_d;
      train_cnt_q  <= train_cnt_d;
      burst_q      <= burst_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic: dropping enable always returns to OFF.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:   if (enable) state_d = ST_TRAIN;
      ST_TRAIN: begin
        if (!enable)                        state_d = ST_OFF;
        else if (train_cnt_q == TRAIN_LAST) state_d = ST_IDLE;
      end
      ST_IDLE, ST_SEND: begin
        if (!enable)       state_d = ST_OFF;
        else if (grant_any) state_d = ST_SEND;
        else               state_d = ST_IDLE;
      end
      default:  state_d = ST_OFF;
    endcase
  end

  // Output logic: next TX word, counters and arbitration bookkeeping.
  always_comb begin
    tx_data_d    = '0;
    tx_valid_d   = 1'b0;
    tx_active_d  = 1'b0;
    train_cnt_d  = train_cnt_q;
    burst_d      = burst_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    if (!enable) begin
      train_cnt_d = '0;
      burst_d     = '0;
    end else begin
      unique case (state_q)
        ST_OFF: train_cnt_d = '0;
        ST_TRAIN: begin
          tx_data_d   = COM_WORD;
          tx_active_d = 1'b1;
          train_cnt_d = train_cnt_q + CW'(1);
        end
        ST_IDLE, ST_SEND: begin
          tx_active_d = 1'b1;
          if (grant_any) begin
            tx_data_d    = grant_pick ? bus.req1_data : bus.req0_data;
            tx_valid_d   = 1'b1;
            last_grant_d = grant_pick;
            if (grant_pick == owner_q) begin
              burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
            end else begin
              owner_d = grant_pick;
              burst_d = BW'(1);
            end
          end else begin
            tx_data_d = IDLE_WORD;
            burst_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_active = tx_active_q;
  assign state         = state_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: directed vector table, hand-written reset/disable
// sequences, then random traffic compared against a behavioural model.
module tb_tx_scheduler;

  localparam logic [31:0] COM  = 32'hBCBCBCBC;
  localparam logic [31:0] IDLW = 32'h7C7C7C7C;
  localparam int          INIT = 4;
  localparam int          MAXB = 4;

  logic       clk_f = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] state;

  tx_scheduler_if bus ();

  tx_scheduler dut (
    .clk_f  (clk_f),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .state  (state)
  );

  always #5 clk_f = ~clk_f;

  typedef struct {
    logic        en, v0, v1;
    logic [31:0] d0, d1;
    logic        r0, r1;
    logic [31:0] tx;
    logic        tv, ta;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural model: link phase, training words sent, and round-robin bookkeeping.
  int          m_phase;     // 0 off, 1 training, 2 idle, 3 sending
  int          m_trained;
  int          m_owner, m_burst, m_last;
  logic [31:0] m_tx;
  logic        m_tv, m_ta;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, input logic v0, input logic [31:0] d0,
                     input logic v1, input logic [31:0] d1,
                     input logic r0, input logic r1, input logic [31:0] tx,
                     input logic tv, input logic ta, input logic [1:0] st);
    vec_t v;
    v.en = en; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.tx = tx; v.tv = tv; v.ta = ta; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic en, input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1);
    @(negedge clk_f);
    enable         = en;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] tx, input logic tv,
                            input logic ta, input logic [1:0] st);
    check({tag, ".tx_data"},   bus.tx_data,          tx);
    check({tag, ".tx_valid"},  32'(bus.tx_valid),    32'(tv));
    check({tag, ".tx_active"}, 32'(bus.tx_active),   32'(ta));
    check({tag, ".state"},     32'(state),           32'(st));
  endtask

  function automatic void model_reset();
    m_phase = 0; m_trained = 0; m_owner = 0; m_burst = 0; m_last = 1;
    m_tx = '0; m_tv = 1'b0; m_ta = 1'b0;
  endfunction

  // Which requester the rules grant this cycle, or -1 for none.
  function automatic int model_grant(input logic en, input logic v0, input logic v1);
    logic vld[2];
    vld[0] = v0; vld[1] = v1;
    if (!en || m_phase < 2) return -1;
    if (m_phase == 2 && v0 && v1) return 1 - m_last;
    if (vld[m_owner] && (m_burst < MAXB || !vld[1 - m_owner])) return m_owner;
    if (vld[1 - m_owner]) return 1 - m_owner;
    return -1;
  endfunction

  function automatic void model_step(input logic en, input logic [31:0] d0,
                                     input logic [31:0] d1, input int g);
    m_tx = '0; m_tv = 1'b0; m_ta = 1'b0;
    if (!en) begin
      m_phase = 0; m_trained = 0; m_burst = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_trained = 0;
    end else if (m_phase == 1) begin
      m_tx = COM; m_ta = 1'b1;
      m_trained++;
      if (m_trained == INIT) m_phase = 2;
    end else begin
      m_ta = 1'b1;
      if (g >= 0) begin
        m_tx = (g == 1) ? d1 : d0;
        m_tv = 1'b1;
        m_last = g;
        if (g == m_owner) m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
        else begin m_owner = g; m_burst = 1; end
        m_phase = 3;
      end else begin
        m_tx = IDLW; m_burst = 0; m_phase = 2;
      end
    end
  endfunction

  initial begin
    logic [31:0] d0, d1;
    logic        g;
    logic        en, v0, v1;
    int          mg;

    // ---------------- directed table ----------------
    // Training, then idle fill.
    add(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd1);
    for (int i = 0; i < INIT; i++) add(1, 0, 0, 0, 0, 0, 0, COM, 0, 1, (i == INIT - 1) ? 2'd2 : 2'd1);
    add(1, 0, 0, 0, 0, 0, 0, IDLW, 0, 1, 2'd2);
    add(1, 0, 0, 0, 0, 0, 0, IDLW, 0, 1, 2'd2);
    // req0 back-to-back burst of three words.
    add(1, 1, 32'hFFFFEEEE, 0, 0, 1, 0, 32'hFFFFEEEE, 1, 1, 2'd3);
    add(1, 1, 32'hFFEEEEEE, 0, 0, 1, 0, 32'hFFEEEEEE, 1, 1, 2'd3);
    add(1, 1, 32'h3FE115E6, 0, 0, 1, 0, 32'h3FE115E6, 1, 1, 2'd3);
    add(1, 0, 0, 0, 0, 0, 0, IDLW, 0, 1, 2'd2);
    // Both valid from idle: last winner was req0, so req1 starts; four each, then swap.
    for (int k = 0; k < 9; k++) begin
      g  = (k < 4) || (k == 8);
      d0 = 32'(k);
      d1 = 32'h10000000 | 32'(k);
      add(1, 1, d0, 1, d1, !g, g, g ? d1 : d0, 1, 1, 2'd3);
    end
    add(1, 0, 0, 0, 0, 0, 0, IDLW, 0, 1, 2'd2);
    // req1 alone for six cycles: no burst limit without contention.
    for (int k = 0; k < 6; k++) begin
      d1 = 32'h20000000 | 32'(k);
      add(1, 0, 0, 1, d1, 0, 1, d1, 1, 1, 2'd3);
    end
    add(1, 0, 0, 0, 0, 0, 0, IDLW, 0, 1, 2'd2);
    // Enable dropped on the third word of a burst; re-enable retrains fully.
    add(1, 1, 32'h30000000, 0, 0, 1, 0, 32'h30000000, 1, 1, 2'd3);
    add(1, 1, 32'h30000001, 0, 0, 1, 0, 32'h30000001, 1, 1, 2'd3);
    add(0, 1, 32'h30000002, 0, 0, 0, 0, 32'h0, 0, 0, 2'd0);
    add(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd1);
    for (int i = 0; i < INIT; i++) add(1, 0, 0, 0, 0, 0, 0, COM, 0, 1, (i == INIT - 1) ? 2'd2 : 2'd1);
    add(1, 0, 0, 0, 0, 0, 0, IDLW, 0, 1, 2'd2);
    // Enable toggled mid-training restarts the count; valids ignored while training.
    add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd0);
    add(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd1);
    add(1, 0, 0, 0, 0, 0, 0, COM, 0, 1, 2'd1);
    add(1, 0, 0, 0, 0, 0, 0, COM, 0, 1, 2'd1);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd0);
    add(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd1);
    add(1, 1, 32'hAAAA0000, 1, 32'hBBBB0000, 0, 0, COM, 0, 1, 2'd1);
    for (int i = 1; i < INIT; i++) add(1, 0, 0, 0, 0, 0, 0, COM, 0, 1, (i == INIT - 1) ? 2'd2 : 2'd1);
    add(1, 0, 0, 0, 0, 0, 0, IDLW, 0, 1, 2'd2);

    // ---------------- reset state ----------------
    reset = 1'b1; enable = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    #3;
    check_outs("reset", 32'h0, 1'b0, 1'b0, 2'd0);
    check("reset.req0_ready", 32'(bus.req0_ready), 32'h0);
    check("reset.req1_ready", 32'(bus.req1_ready), 32'h0);
    @(negedge clk_f);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
      check($sformatf("vec%0d.req0_ready", i), 32'(bus.req0_ready), 32'(tbl[i].r0));
      check($sformatf("vec%0d.req1_ready", i), 32'(bus.req1_ready), 32'(tbl[i].r1));
      @(posedge clk_f); #1;
      check_outs($sformatf("vec%0d", i), tbl[i].tx, tbl[i].tv, tbl[i].ta, tbl[i].st);
    end

    // ---------------- reset between edges during SEND ----------------
    drive(1, 1, 32'hDEADBEEF, 0, 0);
    check("midrst.req0_ready", 32'(bus.req0_ready), 32'h1);
    @(posedge clk_f); #1;
    check_outs("midrst.send", 32'hDEADBEEF, 1'b1, 1'b1, 2'd3);
    #2 reset = 1'b1;
    #1;
    check_outs("midrst.async", 32'h0, 1'b0, 1'b0, 2'd0);
    @(negedge clk_f);
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    for (int c = 0; c < INIT + 3; c++) begin
      @(posedge clk_f); #1;
      check($sformatf("midrst.no_resend%0d", c), 32'(bus.tx_valid), 32'h0);
    end

    // ---------------- random traffic against the model ----------------
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 39) != 0);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = $urandom;
      d1 = $urandom;
      drive(en, v0, d0, v1, d1);
      mg = model_grant(en, v0, v1);
      check($sformatf("rnd%0d.req0_ready", c), 32'(bus.req0_ready), (mg == 0) ? 32'h1 : 32'h0);
      check($sformatf("rnd%0d.req1_ready", c), 32'(bus.req1_ready), (mg == 1) ? 32'h1 : 32'h0);
      model_step(en, d0, d1, mg);
      @(posedge clk_f); #1;
      check($sformatf("rnd%0d.tx_data", c),   bus.tx_data,        m_tx);
      check($sformatf("rnd%0d.tx_valid", c),  32'(bus.tx_valid),  32'(m_tv));
      check($sformatf("rnd%0d.tx_active", c), 32'(bus.tx_active), 32'(m_ta));
      check($sformatf("rnd%0d.state", c),     32'(state),         32'(m_phase));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
